// File: rtl/btn_sched_pkg.sv
// Shared constants and event-entry type for the button event scheduler.
// BTN_SCHED_TIMESTAMP_EN adds a cycle-count timestamp to every queued event.
package btn_sched_pkg;

  localparam int DEF_N_BTN      = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ID_W       = 2;
  localparam int TS_W           = 16;

  typedef struct packed {
`ifdef BTN_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
    logic [DEF_ID_W-1:0] id;
  } evt_entry_t;

  // Index width that still works for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts at ptr and wraps.
// No latency; en=0 suppresses every grant.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = btn_sched_pkg::idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (W+1)'(i);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      idx = sum[W-1:0];
      if (en && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; registered count, head data visible combinationally.
// Push ignored when full, pop ignored when empty; head reads as zero while empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   full,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_vld = (count_q != '0);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_rdy & pop_vld;
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Serializes button presses into a queued event stream; press-to-event 2 cycles.
// Backpressure via evt_ready: full queue holds presses pending, repeat press sets overflow. Macro: BTN_SCHED_TIMESTAMP_EN.
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int N_BTN      = DEF_N_BTN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ID_W       = DEF_ID_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_BTN-1:0]            btn_pulse,
  output logic                        evt_valid,
  output logic [ID_W-1:0]             evt_id,
`ifdef BTN_SCHED_TIMESTAMP_EN
  output logic [TS_W-1:0]             evt_ts,
`endif
  input  logic                        evt_ready,
  output logic [N_BTN-1:0]            pending,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = idx_w(N_BTN);

  typedef struct packed {
`ifdef BTN_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    logic [ID_W-1:0] id;
  } entry_t;

  logic [N_BTN-1:0] pending_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic             overflow_q;
  logic [N_BTN-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  logic             any_grant;
  logic             fifo_full;
  entry_t           push_entry;
  entry_t           head_entry;

  rr_arbiter #(.N(N_BTN), .W(PTR_W)) u_arb (
    .req       (pending_q),
    .en        (~fifo_full),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    rr_ptr_nxt = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_nxt = (grant_idx == PTR_W'(N_BTN - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // A pulse on a bit being granted this cycle is a fresh press and re-arms it;
  // a pulse on a bit still waiting is merged away and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~grant) | btn_pulse;
      rr_ptr_q  <= rr_ptr_nxt;
      if (|(btn_pulse & pending_q & ~grant)) overflow_q <= 1'b1;
    end
  end

`ifdef BTN_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  always_comb begin
    push_entry    = '0;
    push_entry.id = ID_W'(grant_idx);
    push_entry.ts = ts_q;
  end

  assign evt_ts = head_entry.ts;
`else
  always_comb begin
    push_entry    = '0;
    push_entry.id = ID_W'(grant_idx);
  end
`endif

  sync_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (any_grant),
    .push_dat (push_entry),
    .full     (fifo_full),
    .pop_vld  (evt_valid),
    .pop_rdy  (evt_ready),
    .pop_dat  (head_entry),
    .count    (fifo_count)
  );

  assign evt_id   = head_entry.id;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler with default parameters.
module tb_button_event_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_pulse;
  logic        evt_valid;
  logic [1:0]  evt_id;
  logic        evt_ready;
  logic [3:0]  pending;
  logic [2:0]  fifo_count;
  logic        overflow;
`ifdef BTN_SCHED_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_q[$];
  int unsigned ts_q[$];

  button_event_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pulse  (btn_pulse),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
`ifdef BTN_SCHED_TIMESTAMP_EN
    .evt_ts     (evt_ts),
`endif
    .evt_ready  (evt_ready),
    .pending    (pending),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    step();
    step();
    exp_q.delete();
    ts_q.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    evt_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!evt_valid) break;
      step();
    end
    chk("drain_done", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
  endtask

  // Every accepted event is matched against the expected order.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(evt_id), 32'hFFFF_FFFF);
      else                   chk("sb_evt_id", 32'(evt_id), exp_q.pop_front());
`ifdef BTN_SCHED_TIMESTAMP_EN
      if (ts_q.size() != 0) chk("sb_evt_ts", 32'(evt_ts), ts_q.pop_front());
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and single-press latency.
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    btn_pulse = 4'b0100; exp_q.push_back(2);
    step();
    btn_pulse = '0;
    chk("t1_pending", 32'(pending), 32'b0100);
    chk("t1_valid_early", 32'(evt_valid), 32'd0);
    step();
    chk("t1_valid", 32'(evt_valid), 32'd1);
    chk("t1_id", 32'(evt_id), 32'd2);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    evt_ready = 1'b1;
    step();
    chk("t1_valid_after_pop", 32'(evt_valid), 32'd0);

    // Simultaneous presses serialized in round-robin order.
    do_reset();
    evt_ready = 1'b1;
    btn_pulse = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back(k);
    step();
    btn_pulse = '0;
    chk("t2_pending", 32'(pending), 32'b1111);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_id_seq", 32'(evt_id), 32'(k));
    end
    step();
    chk("t2_idle", 32'(evt_valid), 32'd0);
    btn_pulse = 4'b1001; exp_q.push_back(0); exp_q.push_back(3);
    step();
    btn_pulse = '0;
    step();
    chk("t2_wrap_id0", 32'(evt_id), 32'd0);
    step();
    chk("t2_wrap_id3", 32'(evt_id), 32'd3);
    step();
    chk("t2_wrap_idle", 32'(evt_valid), 32'd0);

    // Full queue holds presses pending; a repeat press overflows.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      btn_pulse = 4'(1 << (k % 4));
      exp_q.push_back(k % 4);
      step();
    end
    btn_pulse = '0;
    step();
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_pending", 32'(pending), 32'b0001);
    chk("t3_no_overflow", 32'(overflow), 32'd0);
    btn_pulse = 4'b0001;
    step();
    btn_pulse = '0;
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count_hold", 32'(fifo_count), 32'd4);
    drain(20);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Head stability under backpressure, then push+pop at count 2.
    do_reset();
    btn_pulse = 4'b0010; exp_q.push_back(1);
    step();
    btn_pulse = 4'b0100; exp_q.push_back(2);
    step();
    btn_pulse = '0;
    step();
    for (int k = 0; k < 10; k++) begin
      chk("t4_id_hold", 32'(evt_id), 32'd1);
      step();
    end
    chk("t4_count2", 32'(fifo_count), 32'd2);
    btn_pulse = 4'b1000; exp_q.push_back(3);
    step();
    btn_pulse = '0;
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("t4_pushpop_count", 32'(fifo_count), 32'd2);
    chk("t4_pushpop_head", 32'(evt_id), 32'd2);
    drain(20);

    // Reset in the middle of a backlog discards everything.
    do_reset();
    btn_pulse = 4'b0100; exp_q.push_back(2);
    step();
    btn_pulse = 4'b1000; exp_q.push_back(3);
    step();
    btn_pulse = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
    step();
    btn_pulse = 4'b0010;
    step();
    btn_pulse = '0;
    chk("t5_count3", 32'(fifo_count), 32'd3);
    chk("t5_pending", 32'(pending), 32'b0010);
    chk("t5_overflow_set", 32'(overflow), 32'd1);
    evt_ready = 1'b1;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("t5_valid", 32'(evt_valid), 32'd0);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_pending_clr", 32'(pending), 32'd0);
    chk("t5_overflow_clr", 32'(overflow), 32'd0);
    step();
    step();
    chk("t5_stays_idle", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

`ifdef BTN_SCHED_TIMESTAMP_EN
    // Timestamps taken in the grant cycle, counted from the reset edge.
    do_reset();
    evt_ready = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      btn_pulse = '0;
      if (k == 10) begin
        btn_pulse = 4'b0010; exp_q.push_back(1); ts_q.push_back(11);
      end else if (k == 20) begin
        btn_pulse = 4'b0100; exp_q.push_back(2); ts_q.push_back(21);
      end
    end
    btn_pulse = '0;
    chk("ts_sb_empty", 32'(ts_q.size()), 32'd0);
    evt_ready = 1'b0;
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Collects one-cycle press pulses from up to N_BTN push-button conditioning chains (debounce, sync, edge-detect).
- Latches each press as pending and selects one per cycle by round-robin.
- Queues the selected button indices in a small FIFO.
- Presents queued events to one consumer (control FSM / display sequencer) over a valid/ready handshake, so simultaneous presses are serialized, never lost silently.

Parameters:
- N_BTN, 4, number of button pulse inputs (2..8).
- FIFO_DEPTH, 4, event queue entries; power of 2, 2..16.
- ID_W, 2, width of button index; must satisfy 2^ID_W >= N_BTN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_pulse  input  N_BTN  one-cycle press pulses, already synchronous to clk.
- evt_valid  output  1  head of queue holds an event.
- evt_id  output  ID_W  button index of head event; held stable while evt_valid=1 and evt_ready=0.
- evt_ready  input  1  consumer accepts head when evt_valid=1.
- pending  output  N_BTN  latched, not-yet-queued presses.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- overflow  output  1  sticky; set when a press is dropped.

Behaviour:
- Reset (reset=1 at posedge): pending=0, FIFO empty, evt_valid=0, evt_id=0, fifo_count=0, overflow=0, RR pointer=0 (index 0 highest priority). Reset mid-operation discards all queued and pending events.
- Pending latch: pending[i] is set on the cycle after btn_pulse[i]=1 and cleared on the cycle after grant[i].
  - Pulse and grant on the same bit in the same cycle: bit stays set, because the new press is a distinct event.
  - Pulse while pending[i]=1 and not granted that cycle: press is coalesced (dropped) and overflow is set.
- Arbitration (combinational from registered pending and RR pointer):
  - Grant at most one bit per cycle.
  - Search starts at the RR pointer and wraps modulo N_BTN.
  - Grant occurs only when the FIFO is not full at the start of the cycle.
  - On grant of index g, the pointer becomes (g+1) mod N_BTN; otherwise it is unchanged.
- FIFO:
  - Push = any grant; writes index g at wr_ptr.
  - Pop = evt_valid & evt_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: no grant; presses remain pending.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_valid = (count != 0); evt_id = mem[rd_ptr].
- Latency: pulse at cycle t, pending at t+1, pushed at end of t+1, evt_valid=1 at t+2 (queue previously empty). Minimum press-to-event latency is 2 cycles.
- Throughput: 1 event/cycle while evt_ready is held high.
- evt_ready while evt_valid=0 is ignored.
- overflow clears only on reset.

Optional Feature:
- Macro BTN_SCHED_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter (reset to 0, wraps 0xFFFF→0).
  - Adds output evt_ts[15:0], the counter value sampled at the grant cycle and stored alongside the id in each FIFO entry.
  - evt_ts obeys the same stability rule as evt_id.
- Undefined: no counter, no evt_ts port, FIFO entries are ID_W bits wide.

Decomposition:
- Shared package btn_sched_pkg:
  - constants for default N_BTN, FIFO_DEPTH, ID_W, TS_W=16;
  - event entry struct/typedef (id, optional ts).
- Sub-module rr_arbiter (parameter N): inputs req, en, ptr; outputs grant (one-hot), grant_idx, any_grant. Purely combinational.
- The pointer register stays in the parent.

Test Plan:
- Reset, then single btn_pulse=4'b0100 at t=5 → pending[2]=1 at t=6; evt_valid=1, evt_id=2 at t=7; fifo_count=1; with evt_ready=1 at t=7, evt_valid=0 at t=8.
- Simultaneous btn_pulse=4'b1111, evt_ready=1 → ids emerge 0,1,2,3 on consecutive cycles; then btn_pulse=4'b1001 → ids 0,3 (pointer wrapped to 0 after 3).
- evt_ready=0, press buttons 0,1,2,3, then 0 again (FIFO_DEPTH=4) → fifo_count=4, pending[0]=1, overflow=0; one more press of button 0 → overflow=1; release ready → 5 events drained: ids 0,1,2,3,0.
- evt_ready=0 while evt_valid=1 for 10 cycles → evt_id is constant; push and pop in the same cycle at count=2 → count stays 2.
- Reset asserted mid-drain with count=3 and pending=4'b0010 → next cycle: evt_valid=0, fifo_count=0, pending=0, overflow=0.
- With BTN_SCHED_TIMESTAMP_EN defined: pulses on button 1 at t=10 and button 2 at t=20 after reset at t=0 → evt_ts values 11 and 21 respectively.
